// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   Receives PS/2 keyboard device-to-host frames (start, 8 data bits LSB-first,
//   odd parity, stop) and queues the scan-code bytes in a first-word-fall-through
//   FIFO. The FIFO head, occupancy and sticky error flags feed the downstream
//   register file; a read of its data register pops one byte through rd_en.
//
//   Optional feature (compile-time macro PS2_RX_TIMEOUT_EN):
//     defined   - a partial frame idle for TIMEOUT_CYCLES clocks is discarded
//     undefined - a partial frame waits indefinitely for further clock edges
//
// Ports
//   ACLK          in   system clock, rising edge
//   ARESETN       in   asynchronous active-low reset
//   ps2_clk       in   raw PS/2 clock (asynchronous)
//   ps2_data      in   raw PS/2 data (asynchronous)
//   rd_en         in   pop FIFO head; ignored when empty
//   clr_err       in   clear parity_err, frame_err, overflow
//   rd_data       out  FIFO head, 0x00 when empty
//   rd_valid      out  FIFO not empty
//   fifo_count    out  current occupancy
//   frame_strobe  out  1-cycle pulse per byte pushed
//   parity_err    out  sticky: frame dropped on odd-parity failure
//   frame_err     out  sticky: frame dropped because stop bit was 0
//   overflow      out  sticky: good frame dropped because FIFO was full
//
// FSM states
//   state    | meaning
//   ST_IDLE  | waiting for a start bit (data=0 on a sample event)
//   ST_DATA  | shifting in the 8 data bits, LSB first
//   ST_PARITY| capturing the parity bit
//   ST_STOP  | checking stop bit and parity, pushing on success

module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_strobe,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CNW = AW + 1;
  localparam int FCW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers (idle level of both lines is 1)
  // ---------------------------------------------------------------------------
  logic clk_meta, clk_sync;
  logic data_meta, data_sync;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filter: filt_cnt counts consecutive samples that differ from the
  // current filtered level; the FILTER_LEN-th such sample flips the output.
  // ---------------------------------------------------------------------------
  logic           filt_clk;
  logic [FCW-1:0] filt_cnt;
  logic           filt_change;
  logic           sample_evt;

  assign filt_change = (clk_sync != filt_clk) && (filt_cnt == FCW'(FILTER_LEN - 1));
  // falling edge of the filtered clock
  assign sample_evt  = filt_change && filt_clk;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_change) begin
      filt_clk <= clk_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FCW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic       par_ok;
  logic       stop_evt;
  logic       push_req;
  logic       par_bad_evt;
  logic       frm_bad_evt;
  logic       timeout_hit;

  assign par_ok      = ^{shreg, par_bit};
  assign stop_evt    = sample_evt && (state == ST_STOP);
  assign push_req    = stop_evt && data_sync && par_ok;
  assign par_bad_evt = stop_evt && !par_ok;
  assign frm_bad_evt = stop_evt && !data_sync;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign timeout_hit = (state != ST_IDLE) && !sample_evt &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      to_cnt <= '0;
    end else if ((state == ST_IDLE) || sample_evt || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (timeout_hit) begin
      state <= ST_IDLE;
    end else if (sample_evt) begin
      case (state)
        ST_IDLE: begin
          if (!data_sync) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shreg   <= {data_sync, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: begin
          par_bit <= data_sync;
          state   <= ST_STOP;
        end
        ST_STOP: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty;
  logic          do_push, do_pop, ovf_evt;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNW'(FIFO_DEPTH));
  assign do_pop     = rd_en && !fifo_empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign ovf_evt    = push_req && fifo_full && !do_pop;

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= do_push;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + CNW'(1);
        2'b01:   fifo_count <= fifo_count - CNW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rd_valid = !fifo_empty;
  assign rd_data  = fifo_empty ? 8'h00 : mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Sticky flags: a set event beats a simultaneous clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (par_bad_evt)  parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (frm_bad_evt)  frame_err  <= 1'b1;
      else if (clr_err) frame_err  <= 1'b0;
      if (ovf_evt)      overflow   <= 1'b1;
      else if (clr_err) overflow   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed testbench for ps2_scancode_rx. Drives PS/2 frames bit by bit with a
// half-period of H system clocks and checks the FIFO interface and flags.
// The timeout scenario is built only when PS2_RX_TIMEOUT_EN is defined.

module tb_ps2_scancode_rx;

  localparam int H   = 20;
  localparam int FL  = 8;
  localparam int DEP = 16;
  localparam int TO  = 3000;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic       ps2_clk, ps2_data, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] fifo_count;
  logic       frame_strobe, parity_err, frame_err, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int s0;

  ps2_scancode_rx #(
    .FILTER_LEN    (FL),
    .FIFO_DEPTH    (DEP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_count  (fifo_count),
    .frame_strobe(frame_strobe),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (frame_strobe === 1'b1) strobe_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic [10:0] frm(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // Sends the first nb bits of a frame. On the stop bit the push happens on
  // the 10th clock edge after ps2_clk falls (2 sync + FL filter samples).
  task automatic send_bits(input logic [10:0] bits, input int nb,
                           input bit pop_at_stop, input bit chk_lat);
    for (int i = 0; i < nb; i++) begin
      ps2_data = bits[i];
      repeat (H) @(posedge ACLK);
      #1 ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (9) @(posedge ACLK);
        #1;
        if (chk_lat) chk("lat_pre_valid", rd_valid, 0);
        if (pop_at_stop) rd_en = 1'b1;
        @(posedge ACLK);
        #1 rd_en = 1'b0;
        if (chk_lat) begin
          chk("lat_valid", rd_valid, 1);
          chk("lat_strobe", frame_strobe, 1);
        end
        repeat (H - 10) @(posedge ACLK);
      end else begin
        repeat (H) @(posedge ACLK);
      end
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(posedge ACLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(frm(d, odd_par(d), 1'b1), 11, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk(tag, rd_data, exp);
    rd_en = 1'b1;
    @(posedge ACLK);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    @(posedge ACLK);
    #1 clr_err = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (5) @(posedge ACLK);
    #1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_flags", {parity_err, frame_err, overflow, frame_strobe}, 4'b0000);
    ARESETN = 1'b1;
    repeat (5) @(posedge ACLK);
    #1;

    // 1: good frame, latency, pop
    s0 = strobe_cnt;
    send_bits(frm(8'h1C, 1'b0, 1'b1), 11, 1'b0, 1'b1);
    chk("t1_strobes", strobe_cnt - s0, 1);
    chk("t1_valid", rd_valid, 1);
    chk("t1_data", rd_data, 8'h1C);
    chk("t1_count", fifo_count, 1);
    chk("t1_flags", {parity_err, frame_err, overflow}, 3'b000);
    rd_en = 1'b1; @(posedge ACLK); #1 rd_en = 1'b0;
    chk("t1_pop_valid", rd_valid, 0);
    chk("t1_pop_data", rd_data, 8'h00);
    chk("t1_pop_count", fifo_count, 0);

    // 2: parity error, clear, frame error
    s0 = strobe_cnt;
    send_bits(frm(8'h1C, 1'b1, 1'b1), 11, 1'b0, 1'b0);
    chk("t2_perr", {parity_err, frame_err}, 2'b10);
    chk("t2_count", fifo_count, 0);
    pulse_clr();
    chk("t2_perr_clr", parity_err, 0);
    send_bits(frm(8'h1C, 1'b0, 1'b0), 11, 1'b0, 1'b0);
    chk("t2_ferr", {parity_err, frame_err}, 2'b01);
    chk("t2_count2", fifo_count, 0);
    chk("t2_strobes", strobe_cnt - s0, 0);
    pulse_clr();
    chk("t2_ferr_clr", frame_err, 0);

    // 3: fill, overflow, ordered drain
    s0 = strobe_cnt;
    for (int i = 0; i < 16; i++) send_frame(8'(i));
    chk("t3_full_count", fifo_count, 16);
    chk("t3_no_ovf", overflow, 0);
    send_frame(8'hAA);
    chk("t3_ovf_count", fifo_count, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_strobes", strobe_cnt - s0, 16);
    for (int i = 0; i < 16; i++) pop_expect("t3_pop", 8'(i));
    chk("t3_empty", rd_valid, 0);
    pulse_clr();
    chk("t3_ovf_clr", overflow, 0);

    // 4: full FIFO, pop coincident with push
    s0 = strobe_cnt;
    for (int i = 0; i < 16; i++) send_frame(8'(i));
    send_bits(frm(8'h55, odd_par(8'h55), 1'b1), 11, 1'b1, 1'b0);
    chk("t4_count", fifo_count, 16);
    chk("t4_no_ovf", overflow, 0);
    chk("t4_strobes", strobe_cnt - s0, 17);
    for (int i = 1; i < 16; i++) pop_expect("t4_pop", 8'(i));
    pop_expect("t4_last", 8'h55);
    chk("t4_empty", rd_valid, 0);

    // 5: short glitch on ps2_clk is rejected
    ps2_clk = 1'b0;
    repeat (FL - 2) @(posedge ACLK);
    #1 ps2_clk = 1'b1;
    repeat (H) @(posedge ACLK);
    #1;
    s0 = strobe_cnt;
    send_frame(8'h5A);
    chk("t5_strobes", strobe_cnt - s0, 1);
    chk("t5_count", fifo_count, 1);
    chk("t5_data", rd_data, 8'h5A);
    chk("t5_flags", {parity_err, frame_err, overflow}, 3'b000);
    pop_expect("t5_pop", 8'h5A);

`ifdef PS2_RX_TIMEOUT_EN
    // 6: partial frame abandoned by timeout
    send_bits(frm(8'h0F, 1'b0, 1'b1), 5, 1'b0, 1'b0);
    repeat (TO + 50) @(posedge ACLK);
    #1;
    s0 = strobe_cnt;
    send_frame(8'hF0);
    chk("t6_strobes", strobe_cnt - s0, 1);
    chk("t6_count", fifo_count, 1);
    chk("t6_data", rd_data, 8'hF0);
    chk("t6_flags", {parity_err, frame_err, overflow}, 3'b000);
    pop_expect("t6_pop", 8'hF0);
`endif

    // 7: reset mid-frame with bytes queued and a flag set
    send_frame(8'h11);
    send_frame(8'h22);
    send_frame(8'h33);
    send_bits(frm(8'h44, ~odd_par(8'h44), 1'b1), 11, 1'b0, 1'b0);
    chk("t7_count3", fifo_count, 3);
    chk("t7_perr", parity_err, 1);
    send_bits(frm(8'h44, odd_par(8'h44), 1'b1), 4, 1'b0, 1'b0);
    ARESETN = 1'b0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("t7_rst_count", fifo_count, 0);
    chk("t7_rst_valid", rd_valid, 0);
    chk("t7_rst_flags", {parity_err, frame_err, overflow}, 3'b000);
    ARESETN = 1'b1;
    repeat (5) @(posedge ACLK);
    #1;
    send_frame(8'h66);
    chk("t7_after_count", fifo_count, 1);
    chk("t7_after_data", rd_data, 8'h66);
    chk("t7_after_flags", {parity_err, frame_err, overflow}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
